// File: rtl/bcd_to_integer_seq_if.sv
// bcd_to_integer_seq_if
//   Start/done handshake bundle for the sequential BCD -> binary converter.
//   master : the requester; drives start and bcd_in, observes the result.
//   slave  : the converter; samples start/bcd_in, drives busy/done/int_out/err.
//   Signals:
//     start    request a conversion (only honoured while the converter is idle)
//     bcd_in   4*DIGITS-bit BCD operand, most significant digit in the top nibble
//     busy     high while digits are being consumed
//     done     one-cycle pulse marking a fresh int_out/err
//     int_out  BIN_W-bit binary result, held until the next completion
//     err      result contained a nibble above 9 (int_out forced to 0)
interface bcd_to_integer_seq_if #(
  parameter int DIGITS = 2,
  parameter int BIN_W  = 7
);
  logic                  start;
  logic [4*DIGITS-1:0]   bcd_in;
  logic                  busy;
  logic                  done;
  logic [BIN_W-1:0]      int_out;
  logic                  err;

  modport master (
    output start,
    output bcd_in,
    input  busy,
    input  done,
    input  int_out,
    input  err
  );

  modport slave (
    input  start,
    input  bcd_in,
    output busy,
    output done,
    output int_out,
    output err
  );
endinterface

// File: rtl/bcd_to_integer_seq.sv
// bcd_to_integer_seq
//   Sequential multi-digit 8421 BCD -> unsigned binary converter. Consumes one
//   digit per clock, most significant first (acc = acc*10 + digit), so a
//   conversion takes DIGITS+2 cycles including the IDLE and DONE cycles.
//   Any nibble above 9 flags err and forces the result to 0; the conversion
//   still runs its full length so latency is fixed.
//   Ports:
//     clk   rising-edge clock
//     rst   synchronous active-high reset, overrides everything
//     bus   bcd_to_integer_seq_if.slave (start, bcd_in, busy, done, int_out, err)
//   All outputs come straight from flops.
module bcd_to_integer_seq #(
  parameter int DIGITS = 2,
  parameter int BIN_W  = 7
) (
  input  logic                  clk,
  input  logic                  rst,
  bcd_to_integer_seq_if.slave   bus
);

  localparam int ACC_W = BIN_W + 4;
  localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DIGITS - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CONV = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t               state_reg, state_next;
  logic [4*DIGITS-1:0]  shift_reg, shift_next;
  logic [ACC_W-1:0]     acc_reg, acc_next;
  logic                 bad_reg, bad_next;
  logic [IDX_W-1:0]     idx_reg, idx_next;
  logic [BIN_W-1:0]     int_out_reg, int_out_next;
  logic                 err_reg, err_next;
  logic                 busy_reg, busy_next;
  logic                 done_reg, done_next;

  // Digit currently at the head of the shift register and the accumulator
  // after folding it in. x10 is built as x8 + x2 to avoid a multiplier.
  logic [3:0]           digit;
  logic [ACC_W-1:0]     acc_step;
  logic                 bad_step;

  assign digit    = shift_reg[4*DIGITS-1 -: 4];
  assign acc_step = (acc_reg << 3) + (acc_reg << 1) + ACC_W'(digit);
  assign bad_step = bad_reg | (digit > 4'd9);

  always_comb begin
    state_next   = state_reg;
    shift_next   = shift_reg;
    acc_next     = acc_reg;
    bad_next     = bad_reg;
    idx_next     = idx_reg;
    int_out_next = int_out_reg;
    err_next     = err_reg;

    case (state_reg)
      IDLE: begin
        if (bus.start) begin
          shift_next = bus.bcd_in;
          acc_next   = '0;
          bad_next   = 1'b0;
          idx_next   = '0;
          state_next = CONV;
        end
      end
      CONV: begin
        acc_next   = acc_step;
        bad_next   = bad_step;
        shift_next = shift_reg << 4;
        idx_next   = idx_reg + 1'b1;
        if (idx_reg == LAST_IDX) begin
          // Result uses the flag including the digit consumed on this edge.
          state_next   = DONE;
          int_out_next = bad_step ? '0 : acc_step[BIN_W-1:0];
          err_next     = bad_step;
        end
      end
      DONE: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase

    // busy/done are registered copies of the next-state decode so they
    // line up exactly with the state they describe.
    busy_next = (state_next == CONV);
    done_next = (state_next == DONE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg   <= IDLE;
      shift_reg   <= '0;
      acc_reg     <= '0;
      bad_reg     <= 1'b0;
      idx_reg     <= '0;
      int_out_reg <= '0;
      err_reg     <= 1'b0;
      busy_reg    <= 1'b0;
      done_reg    <= 1'b0;
    end else begin
      state_reg   <= state_next;
      shift_reg   <= shift_next;
      acc_reg     <= acc_next;
      bad_reg     <= bad_next;
      idx_reg     <= idx_next;
      int_out_reg <= int_out_next;
      err_reg     <= err_next;
      busy_reg    <= busy_next;
      done_reg    <= done_next;
    end
  end

  assign bus.busy    = busy_reg;
  assign bus.done    = done_reg;
  assign bus.int_out = int_out_reg;
  assign bus.err     = err_reg;

endmodule
